// File: rtl/bounce_gen_pkg.sv
// -----------------------------------------------------------------------------
// bounce_pkg
// Shared definitions for the switch-bounce emulator:
//   - state_e      : FSM state encoding (IDLE / BOUNCE / SETTLE)
//   - LFSR_W       : width of the pseudo-random source
//   - TAP_*        : Fibonacci feedback taps (7,5,4,3)
//   - lfsr_next()  : one shift-left step of the LFSR
//   - clamp_pairs(): bounce-pair count limited to the configured maximum
// -----------------------------------------------------------------------------
package bounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_e;

  localparam int LFSR_W = 8;

  localparam int TAP_A = 7;
  localparam int TAP_B = 5;
  localparam int TAP_C = 4;
  localparam int TAP_D = 3;

  // Shift left; the feedback bit enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D]};
  endfunction

  function automatic logic [2:0] clamp_pairs(input logic [2:0] raw,
                                             input logic [2:0] max_pairs);
    return (raw > max_pairs) ? max_pairs : raw;
  endfunction

endpackage

// File: rtl/bounce_gen_lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// 8-bit Fibonacci LFSR (taps 7,5,4,3) that advances only when en is high.
// Maximal-length taps: starting from a nonzero SEED it never reaches zero.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-high reset, loads SEED
//   en   in   advance strobe (the bounce tick)
//   q    out  current LFSR value
// -----------------------------------------------------------------------------
module lfsr8
  import bounce_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (en) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/bounce_gen.sv
// -----------------------------------------------------------------------------
// bounce_gen
// Switch-bounce emulator: turns a clean level command into a deterministic,
// pseudo-random bouncing waveform that settles at the commanded level.
// Bounce timing is paced by the same tick strobe used by the debouncer.
//
// Parameters:
//   MAX_BOUNCES  (0..7)   maximum bounce pairs per edge
//   SETTLE_TICKS (1..255) ticks noisy_out is held stable before done
//   LFSR_SEED    (!=0)    LFSR reset value
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset (aborts any sequence)
//   tick       in   single-clk pacing strobe
//   clean_in   in   commanded level
//   noisy_out  out  emulated bouncing switch output (registered)
//   busy       out  high while a bounce/settle sequence runs (registered)
//   done       out  one-clk pulse when a sequence completes (registered)
//   edge_cnt   out  [15:0] saturating count of noisy_out transitions
//                   (present only when BOUNCE_GEN_STATS_EN is defined)
// -----------------------------------------------------------------------------
module bounce_gen
  import bounce_pkg::*;
#(
  parameter int                MAX_BOUNCES  = 7,
  parameter int                SETTLE_TICKS = 4,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        clean_in,
  output logic        noisy_out,
  output logic        busy,
  output logic        done
`ifdef BOUNCE_GEN_STATS_EN
  ,
  output logic [15:0] edge_cnt
`endif
);

  localparam logic [2:0] MAX_PAIRS   = 3'(MAX_BOUNCES);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_TICKS - 1);

  state_e            state_q;
  logic              lvl_q;      // level of the last completed sequence
  logic              tgt_q;      // level the running sequence settles at
  logic [3:0]        rem_q;      // toggles still to emit (always even on entry)
  logic [7:0]        scnt_q;     // settle ticks elapsed
  logic              noisy_q;
  logic              busy_q;
  logic              done_q;

  logic [LFSR_W-1:0] lfsr_q;
  logic [2:0]        pairs;
  logic              unused_lfsr_hi;

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (tick),
    .q   (lfsr_q)
  );

  // Only the low bits steer the bounce pattern.
  assign pairs          = clamp_pairs(lfsr_q[2:0], MAX_PAIRS);
  assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lvl_q   <= 1'b0;
      tgt_q   <= 1'b0;
      rem_q   <= 4'd0;
      scnt_q  <= 8'd0;
      noisy_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // No tick needed: the initial edge follows the command immediately.
          if (clean_in != lvl_q) begin
            tgt_q   <= clean_in;
            noisy_q <= clean_in;
            rem_q   <= {pairs, 1'b0};
            busy_q  <= 1'b1;
            scnt_q  <= 8'd0;
            state_q <= (pairs != 3'd0) ? BOUNCE : SETTLE;
          end
        end

        BOUNCE: begin
          // lfsr_q is the pre-advance value on this edge.
          if (tick && lfsr_q[0]) begin
            noisy_q <= ~noisy_q;
            rem_q   <= rem_q - 4'd1;
            if (rem_q == 4'd1) begin
              scnt_q  <= 8'd0;
              state_q <= SETTLE;
            end
          end
        end

        SETTLE: begin
          if (tick) begin
            if (scnt_q == SETTLE_LAST) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              lvl_q   <= tgt_q;
              state_q <= IDLE;
            end else begin
              scnt_q <= scnt_q + 8'd1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign noisy_out = noisy_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef BOUNCE_GEN_STATS_EN
  // Transitions are detected one clk late against a delayed copy of noisy_q;
  // both copies reset to 0 so a reset never registers as an edge.
  logic        noisy_prev_q;
  logic [15:0] edge_cnt_q;
  logic [15:0] edge_cnt_d;

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    edge_cnt_d = edge_cnt_q;
    if ((noisy_prev_q != noisy_q) && (edge_cnt_q != 16'hFFFF)) begin
      edge_cnt_d = edge_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      noisy_prev_q <= 1'b0;
      edge_cnt_q   <= 16'd0;
    end else begin
      noisy_prev_q <= noisy_q;
      edge_cnt_q   <= edge_cnt_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
`endif

endmodule

// File: tb/tb_bounce_gen.sv
// -----------------------------------------------------------------------------
// tb_bounce_gen
// Self-checking bench for bounce_gen. A behavioural model tracks the remaining
// toggles and settle ticks of each sequence and predicts noisy_out/busy/done
// every clock; directed scenarios cover reset, the seed-determined first
// sequence, ignored mid-sequence changes, restart after done, and a
// MAX_BOUNCES=0 instance. Optional edge_cnt checks when BOUNCE_GEN_STATS_EN.
// -----------------------------------------------------------------------------
module tb_bounce_gen;

  localparam int          MAXB   = 7;
  localparam int          SETTLE = 4;
  localparam logic [7:0]  SEED   = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  logic tick;
  logic clean_in;
  logic noisy_out, busy, done;
  logic clean0;
  logic noisy0, busy0, done0;
`ifdef BOUNCE_GEN_STATS_EN
  logic [15:0] edge_cnt, edge_cnt0;
`endif

  always #5 clk = ~clk;

  bounce_gen #(
    .MAX_BOUNCES  (MAXB),
    .SETTLE_TICKS (SETTLE),
    .LFSR_SEED    (SEED)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .clean_in  (clean_in),
    .noisy_out (noisy_out),
    .busy      (busy),
    .done      (done)
`ifdef BOUNCE_GEN_STATS_EN
    ,
    .edge_cnt  (edge_cnt)
`endif
  );

  bounce_gen #(
    .MAX_BOUNCES  (0),
    .SETTLE_TICKS (SETTLE),
    .LFSR_SEED    (SEED)
  ) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .clean_in  (clean0),
    .noisy_out (noisy0),
    .busy      (busy0),
    .done      (done0)
`ifdef BOUNCE_GEN_STATS_EN
    ,
    .edge_cnt  (edge_cnt0)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_lfsr;
  logic       m_lvl, m_tgt, m_noisy, m_busy, m_done;
  int         m_toggles_left;
  int         m_settle_left;

  task automatic model_reset();
    m_lfsr         = SEED;
    m_lvl          = 1'b0;
    m_tgt          = 1'b0;
    m_noisy        = 1'b0;
    m_busy         = 1'b0;
    m_done         = 1'b0;
    m_toggles_left = 0;
    m_settle_left  = 0;
  endtask

  // One clock edge of the reference behaviour with inputs t (tick), c (clean).
  task automatic model_edge(input logic t, input logic c);
    int pairs;
    m_done = 1'b0;
    if (!m_busy) begin
      if (c != m_lvl) begin
        pairs = int'(m_lfsr[2:0]);
        if (pairs > MAXB) pairs = MAXB;
        m_tgt          = c;
        m_noisy        = c;
        m_busy         = 1'b1;
        m_toggles_left = 2 * pairs;
        m_settle_left  = SETTLE;
      end
    end else if (t) begin
      if (m_toggles_left > 0) begin
        if (m_lfsr[0]) begin
          m_noisy        = ~m_noisy;
          m_toggles_left = m_toggles_left - 1;
        end
      end else begin
        m_settle_left = m_settle_left - 1;
        if (m_settle_left == 0) begin
          m_done = 1'b1;
          m_busy = 1'b0;
          m_lvl  = m_tgt;
        end
      end
    end
    if (t) m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  endtask

  // ---------------- stimulus helpers ----------------
  logic prev_noisy;
  int   n_edges;

  task automatic step(input logic t, input logic c);
    @(negedge clk);
    tick     = t;
    clean_in = c;
    model_edge(t, c);
    @(posedge clk);
    #1;
    check("noisy_out", 32'(noisy_out), 32'(m_noisy));
    check("busy",      32'(busy),      32'(m_busy));
    check("done",      32'(done),      32'(m_done));
    if (noisy_out !== prev_noisy) n_edges++;
    prev_noisy = noisy_out;
  endtask

  // Random ticks until the model reports the sequence finished (bounded).
  task automatic run_until_idle(input string tag, input logic c);
    logic t;
    for (int i = 0; i < 400; i++) begin
      t = ($urandom_range(0, 2) == 0);
      step(t, c);
      if (!m_busy) break;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic t;
    logic c;
    int   ticks;

    rst      = 1'b1;
    tick     = 1'b0;
    clean_in = 1'b0;
    clean0   = 1'b0;
    model_reset();
    prev_noisy = 1'b0;
    n_edges    = 0;
    #12;
    check("rst_noisy", 32'(noisy_out), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_busy0", 32'(busy0),     32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Seed 0xA5: 5 bounce pairs -> 1 initial + 10 bounce edges, ends high.
    n_edges = 0;
    step(1'b0, 1'b1);
    check("seqA_start_busy", 32'(busy), 32'd1);
    run_until_idle("seqA_timeout", 1'b1);
    check("seqA_edges", 32'(n_edges), 32'd11);
    check("seqA_final", 32'(noisy_out), 32'd1);
`ifdef BOUNCE_GEN_STATS_EN
    step(1'b0, 1'b1);
    check("seqA_edge_cnt", 32'(edge_cnt), 32'd11);
`endif

    // MAX_BOUNCES=0 instance: single edge, done on the 4th following tick.
    clean0 = 1'b1;
    step(1'($urandom_range(0, 1)), clean_in);
    check("z_start_noisy", 32'(noisy0), 32'd1);
    check("z_start_busy",  32'(busy0),  32'd1);
    check("z_start_done",  32'(done0),  32'd0);
    ticks = 0;
    for (int i = 0; i < 200 && ticks < SETTLE; i++) begin
      t = ($urandom_range(0, 1) == 1);
      step(t, clean_in);
      if (t) ticks++;
      check("z_done",  32'(done0),  32'(t && ticks == SETTLE));
      check("z_busy",  32'(busy0),  32'(ticks < SETTLE));
      check("z_noisy", 32'(noisy0), 32'd1);
    end
    check("z_end_busy", 32'(busy0), 32'd0);
    step(1'b0, clean_in);
    check("z_done_pulse", 32'(done0), 32'd0);

    // Change and restore during a sequence toward 0: nothing follows it.
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    run_until_idle("restore_timeout", 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    check("restore_idle", 32'(busy), 32'd0);

    // Change during a sequence toward 1: a new sequence toward 0 starts one clk after done.
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    run_until_idle("chg_timeout", 1'b0);
    check("chg_level", 32'(noisy_out), 32'd1);
    step(1'b0, 1'b0);
    check("restart_busy",  32'(busy),      32'd1);
    check("restart_noisy", 32'(noisy_out), 32'd0);
    run_until_idle("restart_timeout", 1'b0);
    check("restart_final", 32'(noisy_out), 32'd0);

    // Reset mid-sequence: outputs clear asynchronously, no done afterwards.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst      = 1'b1;
    clean_in = 1'b0;
    clean0   = 1'b0;
    #1;
    check("arst_noisy", 32'(noisy_out), 32'd0);
    check("arst_busy",  32'(busy),      32'd0);
    check("arst_done",  32'(done),      32'd0);
    model_reset();
    prev_noisy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);

    // LFSR back at seed: the first sequence repeats the 11-edge pattern.
    n_edges = 0;
    step(1'b0, 1'b1);
    run_until_idle("seqB_timeout", 1'b1);
    check("seqB_edges", 32'(n_edges), 32'd11);
    check("seqB_final", 32'(noisy_out), 32'd1);

    // Randomised run against the model.
    c = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      t = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) c = ~c;
      step(t, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bounce_gen.md
Name: bounce_gen

Overview:
- Synthesizable switch-bounce emulator; the inverse of Debounce.
- Takes a clean level command and drives a deterministic, pseudo-random bouncing waveform that settles at the commanded level.
- Used for on-board self-test of the Debounce and counter path on the 7-seg project, and as a bench stimulus source.
- Paced by the same tick strobe as Debounce.

Parameters:
- MAX_BOUNCES, 7: maximum bounce pairs per edge; legal range 0..7.
- SETTLE_TICKS, 4: ticks noisy_out is held stable before done; legal range 1..255.
- LFSR_SEED, 8'hA5: reset value of the LFSR; must be nonzero.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  single-clk enable strobe pacing bounce timing.
- clean_in  in  1  commanded (clean) level.
- noisy_out  out  1  emulated bouncing switch output.
- busy  out  1  high while a bounce/settle sequence is in progress.
- done  out  1  one-clk pulse when a sequence completes.

Behaviour:
- Reset: async, active-high. Sets noisy_out=0, busy=0, done=0, lvl=0, tgt=0, rem=0, scnt=0, lfsr=LFSR_SEED, state=IDLE.
- A reset asserted mid-sequence aborts the sequence immediately.
- All outputs are registered.
- LFSR: 8-bit Fibonacci, shift left, new bit0 = q[7]^q[5]^q[4]^q[3].
  - Advances only on clk edges where tick=1, in every state.
  - Never reaches 0.
- States are IDLE, BOUNCE and SETTLE.
- IDLE, on any clk with clean_in != lvl (tick not required):
  - tgt<=clean_in and noisy_out<=clean_in.
  - n = min(lfsr[2:0], MAX_BOUNCES); rem<=2*n, 4-bit field.
  - busy<=1; go to BOUNCE if n!=0, otherwise go to SETTLE with scnt<=0.
  - Latency: clean_in changes before edge k; noisy_out and busy update at edge k.
- BOUNCE, on tick:
  - If lfsr[0]==1 (pre-advance value): noisy_out<=~noisy_out and rem<=rem-1. Otherwise hold.
  - When the decrement makes rem 0, go to SETTLE with scnt<=0.
  - Because rem is even, noisy_out==tgt on exit.
- SETTLE, on tick: scnt<=scnt+1.
  - When scnt reaches SETTLE_TICKS-1 on a tick: done<=1 for one clk, busy<=0, lvl<=tgt, go to IDLE.
- clean_in changes during BOUNCE or SETTLE are ignored (no queueing). IDLE re-compares on the clk after done.
  - A level changed mid-sequence starts a new sequence one clk after done.
  - A level changed and restored mid-sequence causes nothing.
- tick has no effect in IDLE except advancing the LFSR.
- Simultaneous clean_in change and tick in IDLE: the sequence starts. The LFSR also advances, and n uses the pre-advance lfsr.
- noisy_out is glitch-free at clk granularity: at most one transition per tick.

Optional Feature:
- Macro BOUNCE_GEN_STATS_EN.
- Defined: adds output port edge_cnt [15:0].
  - Counts every noisy_out transition, including the initial edge.
  - Saturates at 16'hFFFF; rst clears it to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package bounce_pkg:
  - state encoding IDLE=2'd0, BOUNCE=2'd1, SETTLE=2'd2;
  - LFSR_W=8;
  - tap positions 7,5,4,3.
- Sub-module lfsr8, natural to split out: clk, rst, en(tick), SEED parameter, q[7:0].

Test Plan:
- Reset mid-BOUNCE (rst pulse while busy=1) -> noisy_out=0, busy=0, done=0, lfsr=8'hA5 asynchronously; no done afterwards.
- MAX_BOUNCES=0, SETTLE_TICKS=4, clean_in 0->1 -> noisy_out=1 and busy=1 at the same edge; exactly 4 ticks later done pulses 1 clk, busy=0; no other noisy_out edges.
- Defaults, seed 8'hA5 (lfsr[2:0]=5), clean_in 0->1:
  - noisy_out shows 1 initial + 10 bounce transitions, ends at 1;
  - each toggle coincides with a tick where the reference-model lfsr[0]=1;
  - done occurs 4 ticks after the last toggle.
- clean_in 0->1 then back to 0 during BOUNCE -> the sequence completes at 1; the clk after done, a new sequence starts toward 0 and settles at 0.
- Defaults, noisy_out fed into Debounce (same clk/tick), 20 random clean_in toggles spaced after done -> db_out transitions exactly once per toggle, with final value = clean_in.
- With BOUNCE_GEN_STATS_EN defined, the scenario 3 stimulus -> edge_cnt=11 after done; forced long run saturates at 16'hFFFF.
